// File: rtl/eth_pkg.sv
// Ethernet framing constants, receive status codes and the byte-wide CRC-32 step
// shared by the RX and TX framers.
package eth_pkg;
    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    typedef enum logic [2:0] {
        ERR_OK   = 3'd0,
        ERR_RUNT = 3'd1,
        ERR_FCS  = 3'd2,
        ERR_LONG = 3'd3,
        ERR_PHY  = 3'd4
    } rx_err_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    // MSB-aligned register, wire-order data (d[0] first); residue after a good FCS is CRC_RESIDUE.
    function automatic logic [31:0] next_crc32_d8(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (c[31] ^ d[i]) ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        return c;
    endfunction
endpackage

// File: rtl/eth_crc32_acc.sv
// CRC-32 accumulator: init loads all-ones, en folds in one byte per clock.
module eth_crc32_acc
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     crc <= '1;
        else if (init) crc <= '1;
        else if (en)   crc <= next_crc32_d8(crc, data);
    end
endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, holds back the FCS with a 5-byte delay
// line, checks CRC and length, and streams payload with SOF/EOF/status plus frame counters.
module gmii_rx_framer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_sof,
    output logic             m_eof,
    output logic [2:0]       m_err,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_runt,
    output logic [CNT_W-1:0] cnt_fcs,
    output logic [CNT_W-1:0] cnt_long,
    output logic [CNT_W-1:0] cnt_phy
);
    logic [7:0]      r_rxd;
    logic            r_dv, r_er;
    rx_state_t       r_state, w_nxt;
    logic [4:0][7:0] r_dly;
    logic [10:0]     r_len;
    logic            r_phy;
    logic [31:0]     w_crc;
    logic            w_emit, w_sof, w_eof, w_shift, w_init, w_done;
    rx_err_t         w_err;

    eth_crc32_acc u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (w_init),
        .en    (w_shift),
        .data  (r_rxd),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd <= '0;
            r_dv  <= 1'b0;
            r_er  <= 1'b0;
        end else begin
            r_rxd <= gmii_rxd;
            r_dv  <= gmii_rx_dv;
            r_er  <= gmii_rx_er;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt   = r_state;
        w_emit  = 1'b0;
        w_sof   = 1'b0;
        w_eof   = 1'b0;
        w_err   = ERR_OK;
        w_shift = 1'b0;
        w_init  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE:
                if (r_dv && r_rxd == ETH_PREAMBLE) w_nxt = ST_PREAMBLE;
            ST_PREAMBLE:
                if (!r_dv) w_nxt = ST_IDLE;
                else if (r_rxd == ETH_SFD) begin
                    w_nxt  = ST_DATA;
                    w_init = 1'b1;
                end else if (r_rxd != ETH_PREAMBLE) w_nxt = ST_DROP;
            ST_DATA:
                if (r_dv) begin
                    if (r_len == 11'(MAX_FRAME)) begin
                        // Oversize: close the frame on the oldest held byte, discard the rest.
                        w_emit = 1'b1;
                        w_eof  = 1'b1;
                        w_err  = (r_phy || r_er) ? ERR_PHY : ERR_LONG;
                        w_done = 1'b1;
                        w_nxt  = ST_DROP;
                    end else begin
                        w_shift = 1'b1;
                        w_emit  = (r_len >= 11'd5);
                        w_sof   = (r_len == 11'd5);
                    end
                end else begin
                    w_nxt  = ST_IDLE;
                    w_done = 1'b1;
                    if (r_len >= 11'd5) begin
                        // Oldest held byte is the last payload byte; the four younger ones are FCS.
                        w_emit = 1'b1;
                        w_sof  = (r_len == 11'd5);
                        w_eof  = 1'b1;
                        if (r_phy)                         w_err = ERR_PHY;
                        else if (w_crc != CRC_RESIDUE)     w_err = ERR_FCS;
                        else if (r_len < 11'(MIN_FRAME))   w_err = ERR_RUNT;
                        else                               w_err = ERR_OK;
                    end else begin
                        w_err = ERR_RUNT;
                    end
                end
            ST_DROP:
                if (!r_dv) w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dly <= '0;
            r_len <= '0;
            r_phy <= 1'b0;
        end else begin
            if (w_shift) r_dly <= {r_dly[3:0], r_rxd};
            // Clearing the length empties the delay line logically.
            if (w_init || w_done)            r_len <= '0;
            else if (w_shift && r_len != '1) r_len <= r_len + 11'd1;
            if (w_init)                r_phy <= 1'b0;
            else if (w_shift && r_er)  r_phy <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            m_err   <= '0;
        end else begin
            m_data  <= w_emit ? r_dly[4] : 8'h00;
            m_valid <= w_emit;
            m_sof   <= w_sof;
            m_eof   <= w_eof;
            m_err   <= w_eof ? w_err : ERR_OK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_good <= '0;
            cnt_runt <= '0;
            cnt_fcs  <= '0;
            cnt_long <= '0;
            cnt_phy  <= '0;
        end else if (w_done) begin
            case (w_err)
                ERR_OK:   if (cnt_good != '1) cnt_good <= cnt_good + CNT_W'(1);
                ERR_RUNT: if (cnt_runt != '1) cnt_runt <= cnt_runt + CNT_W'(1);
                ERR_FCS:  if (cnt_fcs  != '1) cnt_fcs  <= cnt_fcs  + CNT_W'(1);
                ERR_LONG: if (cnt_long != '1) cnt_long <= cnt_long + CNT_W'(1);
                ERR_PHY:  if (cnt_phy  != '1) cnt_phy  <= cnt_phy  + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: builds frames with a reference CRC, captures
// every output beat and compares against the payload that was sent.
module tb_gmii_rx_framer;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv, gmii_rx_er;
    logic [7:0]  m_data;
    logic        m_valid, m_sof, m_eof, busy;
    logic [2:0]  m_err;
    logic [15:0] cnt_good, cnt_runt, cnt_fcs, cnt_long, cnt_phy;

    int tests = 0;
    int fails = 0;
    logic [7:0] cap_d[$];
    logic [4:0] cap_f[$];   // {sof, eof, err}
    logic [7:0] expq[$];
    logic [7:0] fr[$];
    int s, e;

    gmii_rx_framer dut (
        .clk(clk), .reset(reset), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
        .gmii_rx_er(gmii_rx_er), .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof),
        .m_eof(m_eof), .m_err(m_err), .busy(busy), .cnt_good(cnt_good),
        .cnt_runt(cnt_runt), .cnt_fcs(cnt_fcs), .cnt_long(cnt_long), .cnt_phy(cnt_phy)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            cap_d.push_back(m_data);
            cap_f.push_back({m_sof, m_eof, m_err});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reflected Ethernet CRC-32, independent of the design's register orientation.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++)
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic drv(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk); #1;
        gmii_rxd = d; gmii_rx_dv = dv; gmii_rx_er = er;
    endtask

    // L = frame length DA..FCS; stop_at >= 0 abandons the frame after that many bytes.
    task automatic send(input int L, input bit bad, input int er_at, input int npre,
                        input int gap, input int stop_at);
        logic [31:0] c;
        c = '1;
        fr.delete();
        for (int i = 0; i < L - 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            fr.push_back(b);
            expq.push_back(b);
            c = crc_upd(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
        if (bad) fr[L-1] = fr[L-1] ^ 8'h01;
        repeat (npre) drv(8'h55, 1'b1, 1'b0);
        drv(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < L; i++) begin
            if (stop_at >= 0 && i == stop_at) return;
            drv(fr[i], 1'b1, (i == er_at));
        end
        repeat (gap) drv(8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk("idle_timeout", {31'd0, busy}, 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic analyze(input string tag, input int si, input int ei, input int nb,
                           input int neof, input int err);
        int n, mism, sofs, eofs;
        n = cap_d.size() - si;
        mism = 0; sofs = 0; eofs = 0;
        chk({tag, "_beats"}, n, nb);
        for (int i = 0; i < n; i++) begin
            if (ei + i >= expq.size() || cap_d[si+i] !== expq[ei+i]) mism++;
            if (cap_f[si+i][4]) sofs++;
            if (cap_f[si+i][3]) eofs++;
        end
        chk({tag, "_data"}, mism, 0);
        chk({tag, "_sofs"}, sofs, neof);
        chk({tag, "_eofs"}, eofs, neof);
        if (n > 0) begin
            chk({tag, "_sof1st"}, {31'd0, cap_f[si][4]}, 1);
            chk({tag, "_eoflast"}, {31'd0, cap_f[si+n-1][3]}, 1);
            chk({tag, "_err"}, {29'd0, cap_f[si+n-1][2:0]}, err);
        end
    endtask

    initial begin
        reset = 1'b1; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_eof", {31'd0, m_eof}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_good", cnt_good, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: good 64-byte frame
        s = cap_d.size(); e = expq.size();
        send(64, 1'b0, -1, 7, 3, -1); wait_idle();
        analyze("good", s, e, 60, 1, 0);
        chk("good_cnt", cnt_good, 1);

        // 2: corrupted FCS
        s = cap_d.size(); e = expq.size();
        send(64, 1'b1, -1, 7, 3, -1); wait_idle();
        analyze("fcs", s, e, 60, 1, 2);
        chk("fcs_cnt", cnt_fcs, 1);
        chk("fcs_good", cnt_good, 1);

        // 3: runt L=40
        s = cap_d.size(); e = expq.size();
        send(40, 1'b0, -1, 7, 3, -1); wait_idle();
        analyze("runt", s, e, 36, 1, 1);
        chk("runt_cnt", cnt_runt, 1);

        // 4: oversize L=1519
        s = cap_d.size(); e = expq.size();
        send(1519, 1'b0, -1, 7, 3, -1); wait_idle();
        analyze("long", s, e, 1514, 1, 3);
        chk("long_cnt", cnt_long, 1);

        // 5: PHY error at byte 20 of a 100-byte frame
        s = cap_d.size(); e = expq.size();
        send(100, 1'b0, 19, 7, 3, -1); wait_idle();
        analyze("phy", s, e, 96, 1, 4);
        chk("phy_cnt", cnt_phy, 1);

        // 6a: bad preamble and carrier extension produce nothing
        s = cap_d.size();
        drv(8'h55, 1'b1, 1'b0); drv(8'h55, 1'b1, 1'b0); drv(8'h55, 1'b1, 1'b0);
        drv(8'h12, 1'b1, 1'b0);
        drv(8'h0F, 1'b0, 1'b1); drv(8'h0F, 1'b0, 1'b1);
        drv(8'h00, 1'b0, 1'b0);
        wait_idle();
        chk("noise_beats", cap_d.size() - s, 0);
        chk("noise_cnt", 32'(cnt_good) + cnt_runt + cnt_fcs + cnt_long + cnt_phy, 5);

        // 6b: back-to-back with one idle cycle between frames
        s = cap_d.size(); e = expq.size();
        send(64, 1'b0, -1, 2, 1, -1);
        send(64, 1'b0, -1, 7, 3, -1);
        wait_idle();
        analyze("b2b", s, e, 120, 2, 0);
        chk("b2b_sof2", (cap_d.size() > s + 60) ? {31'd0, cap_f[s+60][4]} : 32'd0, 1);
        chk("b2b_cnt", cnt_good, 3);

        // 6c: reset partway through a frame
        s = cap_d.size();
        send(64, 1'b0, -1, 7, 0, 30);
        @(posedge clk); #1;
        reset = 1'b1; gmii_rx_dv = 1'b0;
        @(negedge clk);
        chk("mid_valid", {31'd0, m_valid}, 0);
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_cnt", 32'(cnt_good) + cnt_runt + cnt_fcs + cnt_long + cnt_phy, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        begin
            int eofs;
            eofs = 0;
            for (int i = s; i < cap_f.size(); i++) if (cap_f[i][3]) eofs++;
            chk("mid_noeof", eofs, 0);
        end

        // 6d: next frame after reset is received normally
        s = cap_d.size(); e = expq.size();
        send(64, 1'b0, -1, 7, 3, -1); wait_idle();
        analyze("post", s, e, 60, 1, 0);
        chk("post_cnt", cnt_good, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
